// File: rtl/alu_pkg.sv
// Shared types for the ALU and its two-requester arbiter front end.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'd0,
    ALU_AND      = 4'd1,
    ALU_SLL      = 4'd2,
    ALU_SRL      = 4'd3,
    ALU_OR       = 4'd4,
    ALU_XOR      = 4'd5,
    ALU_OUT_ONE  = 4'd6,
    ALU_OUT_ZERO = 4'd7,
    ALU_SRA      = 4'd8,
    ALU_LUI      = 4'd9,
    ALU_SUB      = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } arb_state_t;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response signals of the arbiter, bundled as one bus.
interface alu_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid_i;
  logic [3:0]      req0_op_i;
  logic [XLEN-1:0] req0_a_i;
  logic [XLEN-1:0] req0_b_i;
  logic            req0_ready_o;
  logic            req1_valid_i;
  logic [3:0]      req1_op_i;
  logic [XLEN-1:0] req1_a_i;
  logic [XLEN-1:0] req1_b_i;
  logic            req1_ready_o;
  logic [3:0]      alu_op_o;
  logic [XLEN-1:0] alu_a_o;
  logic [XLEN-1:0] alu_b_o;
  logic [XLEN-1:0] alu_result_i;
  logic            rsp_valid_o;
  logic            rsp_id_o;
  logic [XLEN-1:0] rsp_data_o;
  logic            rsp_ready_i;

  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    output req0_ready_o,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    output req1_ready_o,
    output alu_op_o, alu_a_o, alu_b_o,
    input  alu_result_i,
    output rsp_valid_o, rsp_id_o, rsp_data_o,
    input  rsp_ready_i
  );

  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    input  req0_ready_o,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    input  req1_ready_o,
    input  alu_op_o, alu_a_o, alu_b_o,
    output alu_result_i,
    input  rsp_valid_o, rsp_id_o, rsp_data_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/alu.sv
// Shared ALU with ALU_LAT registered stages; undefined opcodes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);
  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0]                shamt;
  logic [XLEN-1:0]                res_comb;
  logic [ALU_LAT-1:0][XLEN-1:0]   pipe_reg;

  assign shamt = b[SH_W-1:0];

  always_comb begin
    res_comb = '0;
    case (op)
      ALU_ADD:      res_comb = a + b;
      ALU_AND:      res_comb = a & b;
      ALU_SLL:      res_comb = a << shamt;
      ALU_SRL:      res_comb = a >> shamt;
      ALU_OR:       res_comb = a | b;
      ALU_XOR:      res_comb = a ^ b;
      ALU_OUT_ONE:  res_comb = XLEN'(1);
      ALU_OUT_ZERO: res_comb = '0;
      ALU_SRA:      res_comb = $unsigned($signed(a) >>> shamt);
      ALU_LUI:      res_comb = b;
      ALU_SUB:      res_comb = a - b;
      default:      res_comb = '0;
    endcase
  end

  // Operands stay stable for the whole operation, so every stage refills with the same value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg[0] <= res_comb;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  assign result = pipe_reg[ALU_LAT-1];
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one pipelined ALU: IDLE -> EXEC (ALU_LAT cycles) -> RESP.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             last_reg, last_next;
  logic             id_reg, id_next;
  logic [3:0]       op_reg, op_next;
  logic [XLEN-1:0]  a_reg, a_next;
  logic [XLEN-1:0]  b_reg, b_next;

  logic [1:0] valid;
  logic [1:0] grant;
  logic [1:0] ready;
  logic       accept_ok;
  logic       accept;

  assign valid = {bus.req1_valid_i, bus.req0_valid_i};

  rr_arb2 u_rr_arb2 (
    .valid      (valid),
    .last_grant (last_reg),
    .grant      (grant)
  );

  // A new operation may enter when idle, or when the current result leaves this cycle.
  assign accept_ok = !rst && (state_reg == ST_IDLE ||
                              (state_reg == ST_RESP && bus.rsp_ready_i));
  assign ready     = accept_ok ? grant : 2'b00;
  assign accept    = |ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      last_reg  <= 1'b1;
      id_reg    <= 1'b0;
      op_reg    <= ALU_ADD;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      id_reg    <= id_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    id_next    = id_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_IDLE;
      ST_EXEC: begin
        if (cnt_reg == '0) state_next = ST_RESP;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      ST_RESP: if (bus.rsp_ready_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Accepting overrides the plain transitions above (idle start or back-to-back from RESP).
    if (accept) begin
      state_next = ST_EXEC;
      cnt_next   = CNT_LOAD;
      last_next  = grant[1];
      id_next    = grant[1];
      op_next    = grant[1] ? bus.req1_op_i : bus.req0_op_i;
      a_next     = grant[1] ? bus.req1_a_i  : bus.req0_a_i;
      b_next     = grant[1] ? bus.req1_b_i  : bus.req0_b_i;
    end
  end

  assign bus.req0_ready_o = ready[0];
  assign bus.req1_ready_o = ready[1];
  assign bus.alu_op_o     = op_reg;
  assign bus.alu_a_o      = a_reg;
  assign bus.alu_b_o      = b_reg;
  assign bus.rsp_valid_o  = (state_reg == ST_RESP) && !rst;
  assign bus.rsp_id_o     = id_reg;
  assign bus.rsp_data_o   = bus.alu_result_i;
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed check of alu_arbiter + alu against a timestamp/queue reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  alu_arbiter_if #(.XLEN(XLEN)) ifa ();
  alu_arbiter_if #(.XLEN(XLEN)) ifb ();

  alu_arbiter #(.XLEN(XLEN), .ALU_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  alu #(.XLEN(XLEN), .ALU_LAT(LAT_A)) alu_a (.clk(clk), .rst(rst_a), .op(ifa.alu_op_o),
    .a(ifa.alu_a_o), .b(ifa.alu_b_o), .result(ifa.alu_result_i));
  alu_arbiter #(.XLEN(XLEN), .ALU_LAT(LAT_B)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));
  alu #(.XLEN(XLEN), .ALU_LAT(LAT_B)) alu_b (.clk(clk), .rst(rst_b), .op(ifb.alu_op_o),
    .a(ifb.alu_a_o), .b(ifb.alu_b_o), .result(ifb.alu_result_i));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requester drivers for instance A (requests are held until accepted).
  bit [1:0]    v;
  logic [3:0]  opv [2];
  logic [31:0] av  [2];
  logic [31:0] bv  [2];
  bit          refill, rnd_raise;

  // Reference model: one result in flight, due at a fixed cycle after its accept.
  bit          pend;
  int          due;
  bit          pend_id;
  logic [31:0] pend_data;
  bit          last_g;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  int          acc_cyc [2];
  bit          hs_id_q [$];
  logic [31:0] hs_data_q [$];
  int          hs_cyc_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a & b;
      4'd2:  return a << b[4:0];
      4'd3:  return a >> b[4:0];
      4'd4:  return a | b;
      4'd5:  return a ^ b;
      4'd6:  return 32'd1;
      4'd7:  return 32'd0;
      4'd8:  return 32'($signed(a) >>> b[4:0]);
      4'd9:  return b;
      4'd10: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    opv[i] = op; av[i] = a; bv[i] = b; v[i] = 1'b1;
  endtask

  task automatic new_req(input int i);
    set_req(i, 4'($urandom_range(15, 0)), $urandom, $urandom);
  endtask

  task automatic clear_log();
    hs_id_q.delete(); hs_data_q.delete(); hs_cyc_q.delete();
    acc_cyc[0] = -1; acc_cyc[1] = -1;
  endtask

  // One cycle on instance A: entered at a falling edge, leaves at the next falling edge.
  task automatic tick_a(input bit rr);
    bit       exp_rv, acc_ok;
    bit [1:0] exp_r;
    int       win;
    if (rnd_raise) for (int i = 0; i < 2; i++) if (!v[i] && $urandom_range(1, 0) == 1) new_req(i);
    ifa.req0_valid_i = v[0]; ifa.req0_op_i = opv[0]; ifa.req0_a_i = av[0]; ifa.req0_b_i = bv[0];
    ifa.req1_valid_i = v[1]; ifa.req1_op_i = opv[1]; ifa.req1_a_i = av[1]; ifa.req1_b_i = bv[1];
    ifa.rsp_ready_i  = rr;
    #1;
    exp_rv = pend && (cyc >= due);
    acc_ok = !pend || (exp_rv && rr);
    if (v[0] && v[1]) win = last_g ? 0 : 1;
    else              win = v[1] ? 1 : 0;
    exp_r = 2'b00;
    if (acc_ok && v[win]) exp_r[win] = 1'b1;
    check_eq("ready0", 32'(ifa.req0_ready_o), 32'(exp_r[0]));
    check_eq("ready1", 32'(ifa.req1_ready_o), 32'(exp_r[1]));
    check_eq("rsp_valid", 32'(ifa.rsp_valid_o), 32'(exp_rv));
    check_eq("alu_op", 32'(ifa.alu_op_o), 32'(m_op));
    check_eq("alu_a", ifa.alu_a_o, m_a);
    check_eq("alu_b", ifa.alu_b_o, m_b);
    if (exp_rv) begin
      check_eq("rsp_id", 32'(ifa.rsp_id_o), 32'(pend_id));
      check_eq("rsp_data", ifa.rsp_data_o, pend_data);
      if (rr) begin
        $display("rsp id=%0d data=0x%08h cyc=%0d", ifa.rsp_id_o, ifa.rsp_data_o, cyc);
        hs_id_q.push_back(ifa.rsp_id_o);
        hs_data_q.push_back(ifa.rsp_data_o);
        hs_cyc_q.push_back(cyc);
        pend = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (exp_r[i]) begin
        pend = 1'b1; due = cyc + LAT_A + 1; pend_id = 1'(i);
        pend_data = ref_alu(opv[i], av[i], bv[i]);
        last_g = 1'(i); m_op = opv[i]; m_a = av[i]; m_b = bv[i];
        acc_cyc[i] = cyc;
        if (refill) new_req(i);
        else        v[i] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    ifa.req0_valid_i = 1'b1; ifa.req1_valid_i = 1'b1; ifa.rsp_ready_i = 1'b1;
    repeat (3) begin
      #1;
      check_eq("rst_ready0", 32'(ifa.req0_ready_o), 0);
      check_eq("rst_ready1", 32'(ifa.req1_ready_o), 0);
      check_eq("rst_rsp_valid", 32'(ifa.rsp_valid_o), 0);
      @(posedge clk); cyc++; @(negedge clk);
    end
    #1;
    check_eq("rst_alu_op", 32'(ifa.alu_op_o), 0);
    check_eq("rst_alu_a", ifa.alu_a_o, 0);
    check_eq("rst_alu_b", ifa.alu_b_o, 0);
    check_eq("rst_rsp_id", 32'(ifa.rsp_id_o), 0);
    rst_a = 1'b0;
    pend = 1'b0; last_g = 1'b1; m_op = 4'd0; m_a = '0; m_b = '0;
    v = 2'b00; refill = 1'b0; rnd_raise = 1'b0;
    clear_log();
  endtask

  task automatic run_a(input int max, input bit rnd_rdy);
    int k = 0;
    while ((pend || v != 2'b00) && k < max) begin
      tick_a(rnd_rdy ? ($urandom_range(3, 0) != 0) : 1'b1);
      k++;
    end
    check_eq("run_drained", 32'({pend, v}), 0);
  endtask

  initial begin
    int k, ka, kr;
    rst_a = 1'b1; rst_b = 1'b1;
    v = 2'b00; refill = 1'b0; rnd_raise = 1'b0;
    for (int i = 0; i < 2; i++) begin opv[i] = '0; av[i] = '0; bv[i] = '0; end
    ifb.req0_valid_i = 1'b0; ifb.req0_op_i = '0; ifb.req0_a_i = '0; ifb.req0_b_i = '0;
    ifb.req1_valid_i = 1'b0; ifb.req1_op_i = '0; ifb.req1_a_i = '0; ifb.req1_b_i = '0;
    ifb.rsp_ready_i  = 1'b1;
    @(negedge clk);

    // Single ADD: response two cycles after the accept cycle.
    reset_a();
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    run_a(20, 1'b0);
    check_eq("add_count", 32'(hs_id_q.size()), 1);
    if (hs_id_q.size() >= 1) begin
      check_eq("add_id", 32'(hs_id_q[0]), 0);
      check_eq("add_data", hs_data_q[0], 32'd12);
      check_eq("add_latency", 32'(hs_cyc_q[0] - acc_cyc[0]), 2);
    end

    // Contention from reset: req0 first, req1 accepted back-to-back.
    reset_a();
    set_req(0, ALU_SUB, 32'd10, 32'd3);
    set_req(1, ALU_XOR, 32'hF0, 32'h0F);
    run_a(20, 1'b0);
    check_eq("both_count", 32'(hs_id_q.size()), 2);
    if (hs_id_q.size() >= 2) begin
      check_eq("both_id0", 32'(hs_id_q[0]), 0);
      check_eq("both_data0", hs_data_q[0], 32'd7);
      check_eq("both_id1", 32'(hs_id_q[1]), 1);
      check_eq("both_data1", hs_data_q[1], 32'hFF);
      check_eq("b2b_accept", 32'(acc_cyc[1]), 32'(hs_cyc_q[0]));
      check_eq("b2b_period", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 2);
    end

    // Both continuously valid: ids alternate.
    reset_a();
    refill = 1'b1; new_req(0); new_req(1);
    k = 0;
    while (hs_id_q.size() < 6 && k < 60) begin tick_a(1'b1); k++; end
    refill = 1'b0;
    run_a(30, 1'b0);
    check_eq("alt_count", 32'(hs_id_q.size() >= 6), 1);
    for (int i = 0; i < 6 && i < hs_id_q.size(); i++) check_eq("alt_id", 32'(hs_id_q[i]), 32'(i % 2));

    // Consumer stalls three RESP cycles while req1 waits.
    reset_a();
    set_req(0, ALU_SRA, 32'h8000_0000, 32'd4);
    set_req(1, ALU_AND, $urandom, $urandom);
    k = 0;
    while (!(pend && cyc >= due + 3) && k < 20) begin tick_a(1'b0); k++; end
    tick_a(1'b1);
    run_a(20, 1'b0);
    check_eq("stall_count", 32'(hs_id_q.size()), 2);
    if (hs_id_q.size() >= 2) begin
      check_eq("stall_data0", hs_data_q[0], 32'hF800_0000);
      check_eq("stall_hs_cycle", 32'(hs_cyc_q[0] - acc_cyc[0]), 5);
      check_eq("stall_b2b", 32'(acc_cyc[1]), 32'(hs_cyc_q[0]));
    end

    // Reset during EXEC drops the operation; the next one behaves normally.
    reset_a();
    set_req(0, ALU_SLL, 32'd1, 32'd4);
    tick_a(1'b1);
    reset_a();
    repeat (5) tick_a(1'b1);
    check_eq("abort_count", 32'(hs_id_q.size()), 0);
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    run_a(20, 1'b0);
    check_eq("post_rst_count", 32'(hs_id_q.size()), 1);
    if (hs_id_q.size() >= 1) begin
      check_eq("post_rst_data", hs_data_q[0], 32'd2);
      check_eq("post_rst_latency", 32'(hs_cyc_q[0] - acc_cyc[0]), 2);
    end

    // Random traffic with random backpressure, all opcodes including undefined ones.
    reset_a();
    rnd_raise = 1'b1;
    repeat (300) tick_a($urandom_range(3, 0) != 0);
    rnd_raise = 1'b0;
    run_a(100, 1'b1);
    check_eq("rand_traffic", 32'(hs_id_q.size() > 20), 1);

    // Instance B, ALU_LAT=3: req1 OR.
    ifb.req1_valid_i = 1'b1; ifb.req1_op_i = ALU_OR; ifb.req1_a_i = 32'h1; ifb.req1_b_i = 32'h2;
    rst_b = 1'b0;
    ka = -1; kr = -1;
    for (int j = 0; j < 20 && kr < 0; j++) begin
      #1;
      if (ka < 0 && ifb.req1_ready_o) ka = j;
      if (ka >= 0 && ifb.req0_ready_o) check_eq("lat3_ready0", 32'(ifb.req0_ready_o), 0);
      if (kr < 0 && ifb.rsp_valid_o) begin
        kr = j;
        check_eq("lat3_data", ifb.rsp_data_o, 32'd3);
        check_eq("lat3_id", 32'(ifb.rsp_id_o), 1);
        $display("rsp id=%0d data=0x%08h lat3", ifb.rsp_id_o, ifb.rsp_data_o);
      end
      @(posedge clk); cyc++; @(negedge clk);
      if (ka >= 0) ifb.req1_valid_i = 1'b0;
    end
    check_eq("lat3_accepted", 32'(ka >= 0), 1);
    check_eq("lat3_latency", 32'(kr - ka), 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
